hdmi_timing_monitor: RTL and testbench
======================================

HDMI_TIMING_MONITOR -- requirements
Module: hdmi_timing_monitor

Interface
REQ-001 SHALL have parameter C_SYNC_POL, default 1, meaning HSYNC/VSYNC active level (1 = active-high).
REQ-002 SHALL have parameter C_DATA_WIDTH, default 24, meaning pixel width of DATA ({R,G,B}, R in MSBs).
REQ-003 SHALL have port CLK  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port EN  input  1  monitor enable.
REQ-006 SHALL have ports DE, HSYNC and VSYNC, each input 1, carrying the video stream from the hdmi_controller output.
REQ-007 SHALL have port DATA  input  C_DATA_WIDTH  pixel data, valid when DE=1.
REQ-008 SHALL have port FRAME_DONE  output  1  one-cycle pulse when results update.
REQ-009 SHALL have ports H_ACTIVE output 13 and V_ACTIVE output 12, carrying active pixels per line and active lines per frame.
REQ-010 SHALL have ports H_TOTAL output 13 and V_TOTAL output 12, carrying clocks per line and lines per frame.
REQ-011 SHALL have port FRAME_CNT  output  8  completed frames, wrapping 255->0.
REQ-012 SHALL have port FRAME_CRC  output  32  CRC of last frame's active pixels.
REQ-013 SHALL have port ERR  output  3  per-frame error flags; [0] line-width mismatch, [1] geometry change, [2] counter saturation.

Function
REQ-014 SHALL register VSYNC, HSYNC and DE each cycle; frame boundary = VSYNC active in the previous sample and inactive in the current sample; line edge = HSYNC inactive->active.
REQ-015 SHALL implement FSM WAIT_SYNC->MEASURE: leave WAIT_SYNC on the first boundary seen with EN=1, with no FRAME_DONE; in MEASURE, EN=0 returns to WAIT_SYNC; outputs hold their values.
REQ-016 SHALL, at each boundary in MEASURE, register all result outputs and assert FRAME_DONE on the same clock edge that samples the boundary, then clear the working counters.
REQ-017 SHALL count H_TOTAL as clocks between consecutive line edges, reporting the last complete line of the frame.
REQ-018 SHALL count V_TOTAL as line edges within the frame.
REQ-019 SHALL set H_ACTIVE to the DE-high count of the first line with DE; any later line with a nonzero, different count sets ERR[0].
REQ-020 SHALL count V_ACTIVE as DE 0->1 transitions within the frame.
REQ-021 SHALL set ERR[1] when any of the four geometry values differ from the previous reported frame; never set on the first frame after WAIT_SYNC.
REQ-022 SHALL saturate all counters at all-ones and set ERR[2] when saturation occurs.
REQ-023 SHALL attribute a line edge or DE cycle coinciding with a boundary to the new frame.
REQ-024 SHALL compute CRC-32 with poly 0x04C11DB7, init 0xFFFFFFFF, no reflection and no final XOR, absorbing C_DATA_WIDTH bits MSB-first per DE=1 cycle.
REQ-025 SHALL make ERR and FRAME_CRC describe only the frame just reported; they are not sticky.

Reset
REQ-026 SHALL, on RST=1 at a clock edge, zero all outputs and counters, enter WAIT_SYNC and clear sample registers to the inactive sync level.
REQ-027 SHALL discard a partial frame when reset occurs mid-frame; the next boundary only arms the FSM.

Configuration
REQ-028 SHALL, when macro HDMI_MON_CRC_EN is defined, instantiate the CRC logic and drive FRAME_CRC per REQ-024.
REQ-029 SHALL, when HDMI_MON_CRC_EN is undefined, omit the CRC logic and tie FRAME_CRC to 0; all other behaviour is unchanged.

Structure
REQ-030 SHALL place counter widths, ERR bit indices, CRC polynomial/init and the FSM state enum in package hdmi_mon_pkg.
REQ-031 SHALL implement the one-step parallel 24-bit CRC update as sub-module hdmi_mon_crc32 (combinational; state register in parent).

Verification
REQ-032 SHALL verify: 4 frames of 16x8 active within 24x12 total, EN=1 -> 3 FRAME_DONE pulses, H_ACTIVE=16, V_ACTIVE=8, H_TOTAL=24, V_TOTAL=12, ERR=0, FRAME_CNT=3.
REQ-033 SHALL verify: line 5 has 15 DE cycles -> that frame ERR=3'b001, H_ACTIVE=16; next clean frame ERR=0.
REQ-034 SHALL verify: geometry 16x8 then 20x8 -> second report ERR[1]=1, H_ACTIVE=20; third 20x8 frame ERR=0.
REQ-035 SHALL verify: frames with DATA=0 and with incrementing DATA -> FRAME_CRC matches the bench model; with the macro undefined, FRAME_CRC=0.
REQ-036 SHALL verify: RST pulse mid-frame -> outputs 0 next cycle; first post-reset boundary gives no FRAME_DONE; the following one reports correctly.
REQ-037 SHALL verify: HSYNC edge coincident with a boundary -> counted in the new frame (V_TOTAL=12); EN=0 mid-frame -> no further FRAME_DONE, outputs hold.

Source files
------------

// File: rtl/hdmi_mon_pkg.sv
// Shared widths, error-flag positions, CRC constants and FSM states for the HDMI timing monitor.
package hdmi_mon_pkg;

   localparam int H_W   = 13;
   localparam int V_W   = 12;
   localparam int FC_W  = 8;
   localparam int ERR_W = 3;

   localparam int ERR_LINE = 0;
   localparam int ERR_GEOM = 1;
   localparam int ERR_SAT  = 2;

   localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
   localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

   typedef enum logic {
      ST_WAIT_SYNC = 1'b0,
      ST_MEASURE   = 1'b1
   } state_t;

   // One serial CRC-32 step: shift left, fold in the polynomial when the outgoing bit differs.
   function automatic logic [31:0] crc32_shift(input logic [31:0] crc, input logic bit_val);
      logic [31:0] shifted;
      shifted = {crc[30:0], 1'b0};
      return (crc[31] ^ bit_val) ? (shifted ^ CRC_POLY) : shifted;
   endfunction

endpackage

// File: rtl/hdmi_mon_crc32.sv
// Combinational CRC-32 update absorbing one W-bit pixel MSB-first; the running value lives in the parent.
module hdmi_mon_crc32
   import hdmi_mon_pkg::*;
#(
   parameter int W = 24
) (
   input  logic [31:0]  seed,
   input  logic [W-1:0] data,
   output logic [31:0]  result
);

   always_comb begin
      result = seed;
      for (int i = W - 1; i >= 0; i--) begin
         result = crc32_shift(result, data[i]);
      end
   end

endmodule

// File: rtl/hdmi_timing_monitor.sv
// Measures HDMI line/frame geometry per frame and flags line-width, geometry and saturation errors.
// Define HDMI_MON_CRC_EN to build the active-pixel CRC-32; otherwise FRAME_CRC reads 0.
module hdmi_timing_monitor
   import hdmi_mon_pkg::*;
#(
   parameter int C_SYNC_POL   = 1,
   parameter int C_DATA_WIDTH = 24
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    EN,
   input  logic                    DE,
   input  logic                    HSYNC,
   input  logic                    VSYNC,
   input  logic [C_DATA_WIDTH-1:0] DATA,
   output logic                    FRAME_DONE,
   output logic [H_W-1:0]          H_ACTIVE,
   output logic [V_W-1:0]          V_ACTIVE,
   output logic [H_W-1:0]          H_TOTAL,
   output logic [V_W-1:0]          V_TOTAL,
   output logic [FC_W-1:0]         FRAME_CNT,
   output logic [31:0]             FRAME_CRC,
   output logic [ERR_W-1:0]        ERR,
   output state_t                  FSM_STATE
);

   localparam logic ACT = (C_SYNC_POL != 0);

   logic vs_q, hs_q, de_q;
   logic boundary, line_edge, de_rise, close_line;

   assign boundary   = (vs_q == ACT) && (VSYNC != ACT);
   assign line_edge  = (HSYNC == ACT) && (hs_q != ACT);
   assign de_rise    = DE && !de_q;
   assign close_line = line_edge || boundary;

   state_t state_q, state_n;
   logic   report;

   always_comb begin
      state_n = state_q;
      report  = 1'b0;
      case (state_q)
         ST_WAIT_SYNC: if (EN && boundary) state_n = ST_MEASURE;
         ST_MEASURE: begin
            if (!EN)           state_n = ST_WAIT_SYNC;
            else if (boundary) report  = 1'b1;
         end
         default: state_n = ST_WAIT_SYNC;
      endcase
   end

   assign FSM_STATE = state_q;

   logic [H_W-1:0] h_cnt, h_tot_w, de_cnt, h_act_w;
   logic [V_W-1:0] v_tot_w, v_act_w;
   logic           h_valid, h_act_set, line_err_w, sat_err_w, have_prev;

   logic [H_W-1:0] h_cnt_n, h_tot_n, de_cnt_n, h_act_n, h_act_eval;
   logic [V_W-1:0] v_tot_n, v_act_n;
   logic           h_valid_n, h_set_n, h_set_eval, line_err_n, line_err_eval, sat_n, sat_hit;
   logic           geom_chg;
   logic [ERR_W-1:0] err_n;

   // A line closes at the next line edge, or at the boundary for the frame's final line.
   always_comb begin
      h_act_eval    = h_act_w;
      h_set_eval    = h_act_set;
      line_err_eval = line_err_w;
      if (close_line && (de_cnt != '0)) begin
         h_set_eval = 1'b1;
         if (!h_act_set)            h_act_eval    = de_cnt;
         else if (de_cnt != h_act_w) line_err_eval = 1'b1;
      end
   end

   always_comb begin
      h_cnt_n    = h_cnt;
      h_valid_n  = h_valid;
      h_tot_n    = h_tot_w;
      v_tot_n    = v_tot_w;
      v_act_n    = v_act_w;
      de_cnt_n   = de_cnt;
      h_act_n    = h_act_eval;
      h_set_n    = h_set_eval;
      line_err_n = line_err_eval;
      sat_n      = sat_err_w;
      sat_hit    = 1'b0;
      if (boundary) begin
         // Fresh frame: only this cycle's edge/DE events belong to it.
         h_cnt_n    = H_W'(line_edge);
         h_valid_n  = line_edge;
         h_tot_n    = '0;
         v_tot_n    = V_W'(line_edge);
         v_act_n    = V_W'(de_rise);
         de_cnt_n   = H_W'(DE);
         h_act_n    = '0;
         h_set_n    = 1'b0;
         line_err_n = 1'b0;
         sat_n      = 1'b0;
      end else begin
         if (line_edge) begin
            h_valid_n = 1'b1;
            h_cnt_n   = H_W'(1);
            if (h_valid) h_tot_n = h_cnt;
            if (v_tot_w == '1) sat_hit = 1'b1;
            else               v_tot_n = v_tot_w + 1'b1;
         end else if (h_valid) begin
            if (h_cnt == '1) sat_hit = 1'b1;
            else             h_cnt_n = h_cnt + 1'b1;
         end
         if (de_rise) begin
            if (v_act_w == '1) sat_hit = 1'b1;
            else               v_act_n = v_act_w + 1'b1;
         end
         if (line_edge) begin
            de_cnt_n = H_W'(DE);
         end else if (DE) begin
            if (de_cnt == '1) sat_hit  = 1'b1;
            else              de_cnt_n = de_cnt + 1'b1;
         end
         if (sat_hit) sat_n = 1'b1;
      end
   end

   assign geom_chg = have_prev && ((h_act_eval != H_ACTIVE) || (v_act_w != V_ACTIVE) ||
                                   (h_tot_w != H_TOTAL) || (v_tot_w != V_TOTAL));

   always_comb begin
      err_n           = '0;
      err_n[ERR_LINE] = line_err_eval;
      err_n[ERR_GEOM] = geom_chg;
      err_n[ERR_SAT]  = sat_err_w;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         vs_q       <= ~ACT;
         hs_q       <= ~ACT;
         de_q       <= 1'b0;
         state_q    <= ST_WAIT_SYNC;
         h_cnt      <= '0;
         h_valid    <= 1'b0;
         h_tot_w    <= '0;
         v_tot_w    <= '0;
         v_act_w    <= '0;
         de_cnt     <= '0;
         h_act_w    <= '0;
         h_act_set  <= 1'b0;
         line_err_w <= 1'b0;
         sat_err_w  <= 1'b0;
         have_prev  <= 1'b0;
         FRAME_DONE <= 1'b0;
         H_ACTIVE   <= '0;
         V_ACTIVE   <= '0;
         H_TOTAL    <= '0;
         V_TOTAL    <= '0;
         FRAME_CNT  <= '0;
         ERR        <= '0;
      end else begin
         vs_q       <= VSYNC;
         hs_q       <= HSYNC;
         de_q       <= DE;
         state_q    <= state_n;
         h_cnt      <= h_cnt_n;
         h_valid    <= h_valid_n;
         h_tot_w    <= h_tot_n;
         v_tot_w    <= v_tot_n;
         v_act_w    <= v_act_n;
         de_cnt     <= de_cnt_n;
         h_act_w    <= h_act_n;
         h_act_set  <= h_set_n;
         line_err_w <= line_err_n;
         sat_err_w  <= sat_n;
         FRAME_DONE <= report;
         if (state_q == ST_WAIT_SYNC) have_prev <= 1'b0;
         if (report) begin
            H_ACTIVE  <= h_act_eval;
            V_ACTIVE  <= v_act_w;
            H_TOTAL   <= h_tot_w;
            V_TOTAL   <= v_tot_w;
            FRAME_CNT <= FRAME_CNT + 1'b1;
            ERR       <= err_n;
            have_prev <= 1'b1;
         end
      end
   end

`ifdef HDMI_MON_CRC_EN
   logic [31:0] crc_w, crc_seed, crc_step, crc_rep;

   assign crc_seed = boundary ? CRC_INIT : crc_w;

   hdmi_mon_crc32 #(.W(C_DATA_WIDTH)) u_crc (
      .seed   (crc_seed),
      .data   (DATA),
      .result (crc_step)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         crc_w   <= CRC_INIT;
         crc_rep <= '0;
      end else begin
         if (boundary || DE) crc_w <= DE ? crc_step : crc_seed;
         if (report)         crc_rep <= crc_w;
      end
   end

   assign FRAME_CRC = crc_rep;
`else
   logic unused_data;
   assign unused_data = ^DATA;
   assign FRAME_CRC   = '0;
`endif

endmodule

// File: tb/tb_hdmi_timing_monitor.sv
// Bench for hdmi_timing_monitor: 24x12 frames from a vector table, plus reset and enable sequences.
module tb_hdmi_timing_monitor;
   import hdmi_mon_pkg::*;

   localparam int DW = 24;

   logic          clk = 1'b0;
   logic          rst, en, de, hsync, vsync;
   logic [DW-1:0] data;
   logic          frame_done;
   logic [12:0]   h_active, h_total;
   logic [11:0]   v_active, v_total;
   logic [7:0]    frame_cnt;
   logic [31:0]   frame_crc;
   logic [2:0]    err;
   state_t        fsm_state;

   always #5 clk = ~clk;

   hdmi_timing_monitor #(.C_SYNC_POL(1), .C_DATA_WIDTH(DW)) dut (
      .CLK(clk), .RST(rst), .EN(en), .DE(de), .HSYNC(hsync), .VSYNC(vsync), .DATA(data),
      .FRAME_DONE(frame_done), .H_ACTIVE(h_active), .V_ACTIVE(v_active), .H_TOTAL(h_total),
      .V_TOTAL(v_total), .FRAME_CNT(frame_cnt), .FRAME_CRC(frame_crc), .ERR(err),
      .FSM_STATE(fsm_state)
   );

   typedef struct packed {
      logic [12:0] h_act;
      logic [11:0] v_act;
      logic [12:0] h_tot;
      logic [11:0] v_tot;
      logic [7:0]  fcnt;
      logic [31:0] crc;
      logic [2:0]  err;
   } exp_t;

   typedef struct {
      int         de_w;
      int         short_line;
      int         short_w;
      int         mode;
      bit         push;
      int         exp_h;
      logic [2:0] exp_err;
   } vec_t;

   exp_t exp_q[$];
   exp_t last_e;
   exp_t mon_e;
   vec_t vecs[10];

   int         n_tests = 0;
   int         n_fail  = 0;
   int         n_done  = 0;
   int         n_push  = 0;
   int         pix     = 0;
   logic [7:0] fc_model;

   function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [DW-1:0] d);
      logic [31:0] r;
      r = c;
      for (int i = DW - 1; i >= 0; i--) begin
         if (r[31] ^ d[i]) r = (r << 1) ^ 32'h04C11DB7;
         else              r = r << 1;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cycle(input logic v, input logic h, input logic d, input logic [DW-1:0] x);
      @(negedge clk);
      vsync = v;
      hsync = h;
      de    = d;
      data  = x;
   endtask

   // 24 clocks/line, HSYNC at pixels 0-1, DE on lines 2-9 from pixel 4, VSYNC on lines 10-11.
   task automatic drive_frame(input int de_w, input int short_line, input int short_w,
                              input int mode, input int n_lines, input int en_drop_line,
                              input bit push, input int exp_h, input logic [2:0] exp_err);
      logic [31:0]   crc_m;
      logic [DW-1:0] x;
      int            w;
      bit            d_on;
      exp_t          e;
      crc_m = 32'hFFFF_FFFF;
      for (int l = 0; l < n_lines; l++) begin
         for (int p = 0; p < 24; p++) begin
            if (l == en_drop_line && p == 0) en = 1'b0;
            w    = (l == short_line) ? short_w : de_w;
            d_on = (l >= 2) && (l < 10) && (p >= 4) && (p < 4 + w);
            x    = '0;
            if (d_on) begin
               if (mode == 1)      x = DW'(pix);
               else if (mode == 2) x = DW'($urandom);
               pix++;
               crc_m = crc_ref(crc_m, x);
            end
            cycle(l >= 10, p < 2, d_on, x);
         end
      end
      if (push) begin
         fc_model++;
         e.h_act = 13'(exp_h);
         e.v_act = 12'd8;
         e.h_tot = 13'd24;
         e.v_tot = 12'd12;
         e.fcnt  = fc_model;
`ifdef HDMI_MON_CRC_EN
         e.crc   = crc_m;
`else
         e.crc   = 32'h0;
`endif
         e.err   = exp_err;
         exp_q.push_back(e);
         last_e = e;
         n_push++;
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_done"},  32'(frame_done), 32'h0);
      check({tag, "_h_act"}, 32'(h_active),   32'h0);
      check({tag, "_v_act"}, 32'(v_active),   32'h0);
      check({tag, "_h_tot"}, 32'(h_total),    32'h0);
      check({tag, "_v_tot"}, 32'(v_total),    32'h0);
      check({tag, "_fcnt"},  32'(frame_cnt),  32'h0);
      check({tag, "_crc"},   frame_crc,       32'h0);
      check({tag, "_err"},   32'(err),        32'h0);
      check({tag, "_state"}, 32'(fsm_state),  32'(ST_WAIT_SYNC));
   endtask

   always @(negedge clk) begin
      if (frame_done) begin
         n_done++;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_frame_done: got pulse, expected none (frame_cnt=%0d)", frame_cnt);
         end else begin
            mon_e = exp_q.pop_front();
            check("h_active",  32'(h_active),  32'(mon_e.h_act));
            check("v_active",  32'(v_active),  32'(mon_e.v_act));
            check("h_total",   32'(h_total),   32'(mon_e.h_tot));
            check("v_total",   32'(v_total),   32'(mon_e.v_tot));
            check("frame_cnt", 32'(frame_cnt), 32'(mon_e.fcnt));
            check("frame_crc", frame_crc,      mon_e.crc);
            check("err",       32'(err),       32'(mon_e.err));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: run exceeded time limit, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int d0, d1;
      rst = 1'b1; en = 1'b0; de = 1'b0; hsync = 1'b0; vsync = 1'b0; data = '0;
      fc_model = '0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      en  = 1'b1;

      //          de_w short sw  mode push exp_h err
      vecs[0] = '{16, -1,   0,  0,   0,   16,   3'b000};
      vecs[1] = '{16, -1,   0,  0,   1,   16,   3'b000};
      vecs[2] = '{16, -1,   0,  0,   1,   16,   3'b000};
      vecs[3] = '{16, -1,   0,  1,   1,   16,   3'b000};
      vecs[4] = '{16,  5,  15,  2,   1,   16,   3'b001};
      vecs[5] = '{16, -1,   0,  2,   1,   16,   3'b000};
      vecs[6] = '{20, -1,   0,  2,   1,   20,   3'b010};
      vecs[7] = '{20, -1,   0,  1,   1,   20,   3'b000};
      vecs[8] = '{16, -1,   0,  1,   1,   16,   3'b010};
      vecs[9] = '{16, -1,   0,  1,   1,   16,   3'b000};

      for (int i = 0; i < 10; i++) begin
         drive_frame(vecs[i].de_w, vecs[i].short_line, vecs[i].short_w, vecs[i].mode,
                     12, -1, vecs[i].push, vecs[i].exp_h, vecs[i].exp_err);
      end

      // Partial frame (its start reports the last table frame), then reset mid-frame.
      drive_frame(16, -1, 0, 0, 5, -1, 1'b0, 0, 3'b000);
      @(negedge clk);
      rst = 1'b1; de = 1'b0; hsync = 1'b0; vsync = 1'b0; data = '0;
      @(negedge clk);
      check_zero("mid_reset");
      rst = 1'b0;
      fc_model = '0;
      repeat (4) cycle(1'b0, 1'b0, 1'b0, '0);

      drive_frame(16, -1, 0, 1, 12, -1, 1'b0, 16, 3'b000);
      d0 = n_done;
      drive_frame(16, -1, 0, 1, 12, -1, 1'b1, 16, 3'b000);
      check("arm_no_done", 32'(n_done), 32'(d0));
      drive_frame(16, -1, 0, 2, 12, -1, 1'b1, 16, 3'b000);

      // EN drops mid-frame: no further reports, results hold.
      drive_frame(16, -1, 0, 0, 12, 5, 1'b0, 16, 3'b000);
      d1 = n_done;
      drive_frame(16, -1, 0, 0, 12, -1, 1'b0, 16, 3'b000);
      repeat (5) cycle(1'b0, 1'b0, 1'b0, '0);
      check("en_off_no_done",  32'(n_done),    32'(d1));
      check("hold_h_active",   32'(h_active),  32'(last_e.h_act));
      check("hold_v_total",    32'(v_total),   32'(last_e.v_tot));
      check("hold_frame_cnt",  32'(frame_cnt), 32'(last_e.fcnt));
      check("hold_frame_crc",  frame_crc,      last_e.crc);
      check("en_off_state",    32'(fsm_state), 32'(ST_WAIT_SYNC));
      check("queue_drained",   32'(exp_q.size()), 32'h0);
      check("done_count",      32'(n_done),    32'(n_push));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
